// File: rtl/ram_stream_reader.sv
// Read-side master for the shared single-port synchronous RAM: issues a burst of
// sequential reads and streams the returned words out through a 2-entry valid/ready FIFO.
//
// state | meaning
// IDLE  | waiting for Start
// ISSUE | addresses still to be issued
// DRAIN | all addresses issued, waiting for the last word to be accepted
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  RSR_Clk,
    input  logic                  RSR_Reset_InLow,
    input  logic                  RSR_Start,
    input  logic [ADDR_WIDTH-1:0] RSR_Base_Addr,
    input  logic [LEN_WIDTH-1:0]  RSR_Length,
    output logic [ADDR_WIDTH-1:0] RSR_Ram_Address,
    output logic                  RSR_Ram_We,
    output logic                  RSR_Ram_Oe,
    input  logic [DATA_WIDTH-1:0] RSR_Ram_Data_In,
    output logic [DATA_WIDTH-1:0] RSR_Data_Out,
    output logic                  RSR_Valid,
    input  logic                  RSR_Ready,
    output logic                  RSR_Busy,
    output logic                  RSR_Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic [LEN_WIDTH-1:0]  pending_q, pending_d;
    logic                  inflight_q, inflight_d;
    logic                  done_q, done_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [2];

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [1:0]            occ_after;

    always_comb begin
        push = inflight_q;
        pop  = (count_q != 2'd0) && RSR_Ready;
        // Counting this cycle's pop keeps one word per cycle flowing with Ready held high.
        occ_after = count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue     = (state_q == S_ISSUE) && (occ_after < 2'd2);

        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        pending_d  = pop ? (pending_q - LEN_WIDTH'(1)) : pending_q;
        inflight_d = issue;
        done_d     = 1'b0;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (RSR_Start) begin
                    if (RSR_Length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_ISSUE;
                        addr_d    = RSR_Base_Addr;
                        remain_d  = RSR_Length;
                        pending_d = RSR_Length;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    remain_d = remain_q - LEN_WIDTH'(1);
                    if (remain_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The final pop implies the FIFO and the read pipe are both empty.
                if (pop && (pending_q == LEN_WIDTH'(1))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge RSR_Clk or negedge RSR_Reset_InLow) begin
        if (!RSR_Reset_InLow) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            pending_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                mem_q[wr_ptr_q] <= RSR_Ram_Data_In;
            end
        end
    end

    assign RSR_Ram_Address = addr_q;
    assign RSR_Ram_We      = 1'b0;
    assign RSR_Busy        = (state_q != S_IDLE);
    assign RSR_Ram_Oe      = RSR_Busy;
    assign RSR_Valid       = (count_q != 2'd0);
    assign RSR_Data_Out    = mem_q[rd_ptr_q];
    assign RSR_Done        = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model, queue-based reference of the burst
// contents and handshake/Done timing, directed scenarios plus random bursts.
module tb_ram_stream_reader;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 11;
    localparam int RAM_WORDS = 1 << AW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [AW-1:0] base  = '0;
    logic [LW-1:0] len   = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          ram_oe;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] dout;
    logic          valid;
    logic          busy;
    logic          done;

    logic [DW-1:0] ram [RAM_WORDS];

    int n_vec  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] hs_log[$];
    logic [AW-1:0] alog[$];
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit            nb, nd, hs;
    logic [DW-1:0] w;
    bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .RSR_Clk         (clk),
        .RSR_Reset_InLow (rst_n),
        .RSR_Start       (start),
        .RSR_Base_Addr   (base),
        .RSR_Length      (len),
        .RSR_Ram_Address (ram_addr),
        .RSR_Ram_We      (ram_we),
        .RSR_Ram_Oe      (ram_oe),
        .RSR_Ram_Data_In (ram_dout),
        .RSR_Data_Out    (dout),
        .RSR_Valid       (valid),
        .RSR_Ready       (ready),
        .RSR_Busy        (busy),
        .RSR_Done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= ram[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string name, input int first, input int cnt);
        chk({name, "_count"}, hs_log.size(), cnt);
        for (int i = 0; i < cnt && i < hs_log.size(); i++)
            chk({name, "_word"}, hs_log[i], (first + i) & 8'hFF);
    endtask

    // Reference model: what the stream must look like after the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_busy     = 1'b0;
            m_done     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("busy", busy, m_busy);
            chk("oe", ram_oe, m_busy);
            chk("done", done, m_done);
            chk("we", ram_we, 0);
            if (prev_stall) begin
                chk("stall_valid", valid, 1);
                chk("stall_data", dout, prev_data);
            end
            if (valid && exp_q.size() == 0) chk("spurious_valid", valid, 0);
            hs = valid && ready;
            nb = m_busy;
            nd = 1'b0;
            if (hs && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("data", dout, w);
                hs_log.push_back(dout);
                if (exp_q.size() == 0) begin
                    nb = 1'b0;
                    nd = 1'b1;
                end
            end
            if (!m_busy && start) begin
                if (len == '0) begin
                    nd = 1'b1;
                end else begin
                    nb = 1'b1;
                    for (int i = 0; i < int'(len); i++)
                        exp_q.push_back(ram[(int'(base) + i) % RAM_WORDS]);
                end
            end
            m_busy     = nb;
            m_done     = nd;
            prev_stall = valid && !ready;
            prev_data  = dout;
        end
    end

    task automatic start_burst(input logic [AW-1:0] b, input logic [LW-1:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // mode 0: Ready held high, 1: fixed 1,0,0,1,0,1 pattern, 2: random Ready
    task automatic run_idle(input int mode);
        int n = 0;
        while (busy) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = pat[n % 6];
                default: ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk);
            #1;
            n++;
            if (n > 1000) begin
                n_vec++;
                n_fail++;
                $display("FAIL timeout: busy still high after %0d cycles", n);
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] rb;
        logic [LW-1:0] rl;
        int g;

        for (int a = 0; a < RAM_WORDS; a++) ram[a] = a[7:0];
        rst_n = 1'b0;
        #7;
        chk("rst_addr", ram_addr, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_oe", ram_oe, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic burst, latency and throughput
        ready = 1'b1;
        hs_log.delete();
        start_burst(10'h010, 11'd4);
        chk("t1_busy", busy, 1);
        chk("t1_addr", ram_addr, 10'h010);
        chk("t1_valid_k", valid, 0);
        @(posedge clk);
        #1 chk("t1_valid_k1", valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t1_valid", valid, 1);
            chk("t1_data", dout, 8'h10 + i);
        end
        @(posedge clk);
        #1;
        chk("t1_valid_end", valid, 0);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        @(posedge clk);
        #1 chk("t1_done_pulse", done, 0);
        chk_seq("t1", 8'h10, 4);

        // address wrap
        hs_log.delete();
        alog.delete();
        start_burst(10'h3FE, 11'd4);
        alog.push_back(ram_addr);
        g = 0;
        while (busy && g < 100) begin
            @(posedge clk);
            #1;
            if (ram_addr != alog[$]) alog.push_back(ram_addr);
            g++;
        end
        chk("t2_addr_count_ok", alog.size() >= 4, 1);
        for (int i = 0; i < 4 && i < alog.size(); i++)
            chk("t2_addr", alog[i], (10'h3FE + i) % RAM_WORDS);
        chk_seq("t2", 8'hFE, 4);
        @(posedge clk);
        #1;

        // backpressure with a fixed Ready pattern
        hs_log.delete();
        start_burst(10'h020, 11'd8);
        run_idle(1);
        chk_seq("t3", 8'h20, 8);
        @(posedge clk);
        #1;

        // zero length
        ready = 1'b1;
        start_burst(10'h155, 11'd0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_valid", valid, 0);
        @(posedge clk);
        #1;
        chk("t4_done_pulse", done, 0);
        chk("t4_busy_after", busy, 0);

        // Start while busy is ignored
        hs_log.delete();
        start_burst(10'h100, 11'd5);
        @(posedge clk);
        #1;
        start_burst(10'h200, 11'd3);
        run_idle(0);
        chk_seq("t4b", 8'h00, 5);
        @(posedge clk);
        #1 chk("t4b_idle", busy, 0);

        // reset mid-burst, then a clean burst
        ready = 1'b1;
        hs_log.delete();
        start_burst(10'h000, 11'd8);
        g = 0;
        while (hs_log.size() < 3 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("t5_three_words", hs_log.size(), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_oe", ram_oe, 0);
        chk("t5_done", done, 0);
        chk("t5_dout", dout, 0);
        chk("t5_addr", ram_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        hs_log.delete();
        start_burst(10'h040, 11'd2);
        run_idle(0);
        chk_seq("t5", 8'h40, 2);
        @(posedge clk);
        #1;

        // Start in the Done cycle
        start_burst(10'h080, 11'd2);
        g = 0;
        while (!done && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("t6_done_seen", done, 1);
        hs_log.delete();
        start_burst(10'h090, 11'd3);
        chk("t6_busy", busy, 1);
        chk("t6_valid_k", valid, 0);
        @(posedge clk);
        #1 chk("t6_valid_k1", valid, 0);
        @(posedge clk);
        #1;
        chk("t6_valid_k2", valid, 1);
        chk("t6_data", dout, 8'h90);
        run_idle(0);
        chk_seq("t6", 8'h90, 3);

        // random bursts over random RAM contents with random Ready
        for (int a = 0; a < RAM_WORDS; a++) ram[a] = 8'($urandom);
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            rb = AW'($urandom_range(0, RAM_WORDS - 1));
            rl = ($urandom_range(0, 7) == 0) ? LW'(0) : LW'($urandom_range(1, 12));
            start_burst(rb, rl);
            if (rl != '0 && $urandom_range(0, 2) == 0) begin
                start_burst(AW'($urandom_range(0, RAM_WORDS - 1)), LW'($urandom_range(0, 12)));
            end
            run_idle(2);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
